// File: rtl/pd_debug_pkg.sv
// Shared widths, read address map and status bit positions for the PD debug counter block.
package pd_debug_pkg;

    localparam int unsigned PD_PACKET_SIZE_WIDTH = 14;
    localparam int unsigned PD_CNT_WIDTH         = 32;
    localparam int unsigned PD_BYTE_CNT_WIDTH    = 48;

    typedef enum logic [3:0] {
        ADDR_F1_CNT     = 4'd0,
        ADDR_F2_CNT     = 4'd1,
        ADDR_CAP_CNT    = 4'd2,
        ADDR_TOT_CNT    = 4'd3,
        ADDR_F1_BYTE_LO = 4'd4,
        ADDR_F1_BYTE_HI = 4'd5,
        ADDR_F2_BYTE_LO = 4'd6,
        ADDR_F2_BYTE_HI = 4'd7,
        ADDR_CAP_WORD   = 4'd8,
        ADDR_STATUS     = 4'd9
    } pd_dbg_cnt_addr_e;

    // Status word; the six overflow bits are contiguous from ST_OVF_F1 upwards.
    localparam int unsigned ST_CAP_F1    = 0;
    localparam int unsigned ST_CAP_F2    = 1;
    localparam int unsigned ST_CAP_VALID = 3;
    localparam int unsigned ST_OVF_F1    = 4;
    localparam int unsigned ST_OVF_F2    = 5;
    localparam int unsigned ST_OVF_CAP   = 6;
    localparam int unsigned ST_OVF_TOT   = 7;
    localparam int unsigned ST_OVF_F2B   = 8;
    localparam int unsigned ST_OVF_F1B   = 9;

endpackage

// File: rtl/pd_debug_cnt_unit.sv
// Single counter: clear, add zero-extended amount, wrap or saturate, carry-out pulse.
// Saturation is selected by defining PD_DEBUG_CNT_SATURATE_EN.
module pd_debug_cnt_unit #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          inc_i,
    input  logic [AW-1:0] amount_i,
    input  logic          clr_i,
    output logic [W-1:0]  cnt_o,
    output logic          ovf_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] base;
    logic [W:0]   sum;

    // Clear applies first so a same-cycle increment lands on zero and is not lost.
    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        sum   = {1'b0, base} + (W+1)'(amount_i);
        ovf_o = inc_i & sum[W];
        cnt_d = base;
        if (inc_i) begin
`ifdef PD_DEBUG_CNT_SATURATE_EN
            cnt_d = sum[W] ? '1 : sum[W-1:0];
`else
            cnt_d = sum[W-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pd_debug_cnt.sv
// PD debug statistics: six counters, sticky capture word and a one-cycle CIF read port.
// Counters saturate instead of wrapping when PD_DEBUG_CNT_SATURATE_EN is defined.
module pd_debug_cnt
    import pd_debug_pkg::*;
#(
    parameter int unsigned CNT_WIDTH         = PD_CNT_WIDTH,
    parameter int unsigned BYTE_CNT_WIDTH    = PD_BYTE_CNT_WIDTH,
    parameter int unsigned PACKET_SIZE_WIDTH = PD_PACKET_SIZE_WIDTH
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         dbg2cif_e_debug_pd_field1_cnt_inc,
    input  logic                         dbg2cif_e_debug_pd_field2_cnt_inc,
    input  logic                         dbg2cif_e_debug_pd_capture_match_cnt_inc,
    input  logic                         dbg2cif_e_debug_pd_total_pd_cnt_inc,
    input  logic                         dbg2cif_e_debug_pd_field1_byte_cnt_inc,
    input  logic                         dbg2cif_e_debug_pd_field2_byte_cnt_inc,
    input  logic [PACKET_SIZE_WIDTH-1:0] dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount,
    input  logic                         dbg2cif_e_debug_pd_capture_match_field1,
    input  logic                         dbg2cif_e_debug_pd_capture_match_field2,
    input  logic [31:0]                  dbg2cif_c_debug_pd_out,
    input  logic                         cif2dbg_c_debug_pd_cnt_clr_on_rd,
    input  logic                         cif2dbg_e_debug_pd_cnt_clr_all,
    input  logic                         cif2dbg_e_debug_pd_cnt_rd_req,
    input  logic [3:0]                   cif2dbg_c_debug_pd_cnt_rd_addr,
    output logic                         dbg2cif_e_debug_pd_cnt_rd_ack,
    output logic [31:0]                  dbg2cif_c_debug_pd_cnt_rd_data,
    output logic                         dbg2cif_c_debug_pd_capture_valid
);

    pd_dbg_cnt_addr_e          rd_addr_e;
    logic                      rd_clr, clr_all;
    logic                      clr_f1, clr_f2, clr_cap, clr_tot, clr_f1b, clr_f2b;
    logic                      cap_clr, ovf_clr, rd_f1_lo, rd_f2_lo;
    logic [CNT_WIDTH-1:0]      f1_cnt, f2_cnt, cap_cnt, tot_cnt;
    logic [BYTE_CNT_WIDTH-1:0] f1_byte, f2_byte;
    logic [5:0]                ovf_p;
    logic [5:0]                ovf_q;
    logic [31:0]               f1_hi_q, f2_hi_q;
    logic [31:0]               cap_word_q;
    logic                      cap_valid_q, cap_f1_q, cap_f2_q;
    logic                      cap_valid_eff, cap_strobe;
    logic                      rd_ack_q;
    logic [31:0]               rd_data_q;
    logic [31:0]               rd_mux, status;

    assign rd_addr_e = pd_dbg_cnt_addr_e'(cif2dbg_c_debug_pd_cnt_rd_addr);
    assign clr_all   = cif2dbg_e_debug_pd_cnt_clr_all;
    assign rd_clr    = cif2dbg_e_debug_pd_cnt_rd_req & cif2dbg_c_debug_pd_cnt_clr_on_rd;
    assign rd_f1_lo  = cif2dbg_e_debug_pd_cnt_rd_req & (rd_addr_e == ADDR_F1_BYTE_LO);
    assign rd_f2_lo  = cif2dbg_e_debug_pd_cnt_rd_req & (rd_addr_e == ADDR_F2_BYTE_LO);

    assign clr_f1  = clr_all | (rd_clr & (rd_addr_e == ADDR_F1_CNT));
    assign clr_f2  = clr_all | (rd_clr & (rd_addr_e == ADDR_F2_CNT));
    assign clr_cap = clr_all | (rd_clr & (rd_addr_e == ADDR_CAP_CNT));
    assign clr_tot = clr_all | (rd_clr & (rd_addr_e == ADDR_TOT_CNT));
    assign clr_f1b = clr_all | (rd_clr & (rd_addr_e == ADDR_F1_BYTE_LO));
    assign clr_f2b = clr_all | (rd_clr & (rd_addr_e == ADDR_F2_BYTE_LO));
    assign cap_clr = clr_all | (rd_clr & (rd_addr_e == ADDR_CAP_WORD));
    assign ovf_clr = clr_all | (rd_clr & (rd_addr_e == ADDR_STATUS));

    pd_debug_cnt_unit #(.W(CNT_WIDTH), .AW(1)) u_f1_cnt (
        .clk, .rstn, .inc_i(dbg2cif_e_debug_pd_field1_cnt_inc), .amount_i(1'b1),
        .clr_i(clr_f1), .cnt_o(f1_cnt), .ovf_o(ovf_p[0]));

    pd_debug_cnt_unit #(.W(CNT_WIDTH), .AW(1)) u_f2_cnt (
        .clk, .rstn, .inc_i(dbg2cif_e_debug_pd_field2_cnt_inc), .amount_i(1'b1),
        .clr_i(clr_f2), .cnt_o(f2_cnt), .ovf_o(ovf_p[1]));

    pd_debug_cnt_unit #(.W(CNT_WIDTH), .AW(1)) u_cap_cnt (
        .clk, .rstn, .inc_i(dbg2cif_e_debug_pd_capture_match_cnt_inc), .amount_i(1'b1),
        .clr_i(clr_cap), .cnt_o(cap_cnt), .ovf_o(ovf_p[2]));

    pd_debug_cnt_unit #(.W(CNT_WIDTH), .AW(1)) u_tot_cnt (
        .clk, .rstn, .inc_i(dbg2cif_e_debug_pd_total_pd_cnt_inc), .amount_i(1'b1),
        .clr_i(clr_tot), .cnt_o(tot_cnt), .ovf_o(ovf_p[3]));

    pd_debug_cnt_unit #(.W(BYTE_CNT_WIDTH), .AW(PACKET_SIZE_WIDTH)) u_f2_byte (
        .clk, .rstn, .inc_i(dbg2cif_e_debug_pd_field2_byte_cnt_inc),
        .amount_i(dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
        .clr_i(clr_f2b), .cnt_o(f2_byte), .ovf_o(ovf_p[4]));

    pd_debug_cnt_unit #(.W(BYTE_CNT_WIDTH), .AW(PACKET_SIZE_WIDTH)) u_f1_byte (
        .clk, .rstn, .inc_i(dbg2cif_e_debug_pd_field1_byte_cnt_inc),
        .amount_i(dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
        .clr_i(clr_f1b), .cnt_o(f1_byte), .ovf_o(ovf_p[5]));

    // A read-clear of the capture word frees the slot for a strobe in the same cycle.
    assign cap_valid_eff = cap_clr ? 1'b0 : cap_valid_q;
    assign cap_strobe    = dbg2cif_e_debug_pd_capture_match_field1 |
                           dbg2cif_e_debug_pd_capture_match_field2;

    always_comb begin
        status                     = '0;
        status[ST_CAP_F1]          = cap_f1_q;
        status[ST_CAP_F2]          = cap_f2_q;
        status[ST_CAP_VALID]       = cap_valid_q;
        status[ST_OVF_F1 +: 6]     = ovf_q;
    end

    always_comb begin
        rd_mux = '0;
        case (rd_addr_e)
            ADDR_F1_CNT:     rd_mux = 32'(f1_cnt);
            ADDR_F2_CNT:     rd_mux = 32'(f2_cnt);
            ADDR_CAP_CNT:    rd_mux = 32'(cap_cnt);
            ADDR_TOT_CNT:    rd_mux = 32'(tot_cnt);
            ADDR_F1_BYTE_LO: rd_mux = f1_byte[31:0];
            ADDR_F1_BYTE_HI: rd_mux = f1_hi_q;
            ADDR_F2_BYTE_LO: rd_mux = f2_byte[31:0];
            ADDR_F2_BYTE_HI: rd_mux = f2_hi_q;
            ADDR_CAP_WORD:   rd_mux = cap_word_q;
            ADDR_STATUS:     rd_mux = status;
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f1_hi_q     <= '0;
            f2_hi_q     <= '0;
            ovf_q       <= '0;
            cap_word_q  <= '0;
            cap_valid_q <= 1'b0;
            cap_f1_q    <= 1'b0;
            cap_f2_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_ack_q <= cif2dbg_e_debug_pd_cnt_rd_req;
            if (cif2dbg_e_debug_pd_cnt_rd_req) begin
                rd_data_q <= rd_mux;
            end

            if (clr_all) begin
                f1_hi_q <= '0;
                f2_hi_q <= '0;
            end else begin
                if (rd_f1_lo) f1_hi_q <= 32'(f1_byte >> 32);
                if (rd_f2_lo) f2_hi_q <= 32'(f2_byte >> 32);
            end

            ovf_q <= (ovf_clr ? 6'b0 : ovf_q) | ovf_p;

            if (!cap_valid_eff && cap_strobe) begin
                cap_word_q  <= dbg2cif_c_debug_pd_out;
                cap_valid_q <= 1'b1;
                cap_f1_q    <= dbg2cif_e_debug_pd_capture_match_field1;
                cap_f2_q    <= dbg2cif_e_debug_pd_capture_match_field2;
            end else if (cap_clr) begin
                cap_word_q  <= '0;
                cap_valid_q <= 1'b0;
                cap_f1_q    <= 1'b0;
                cap_f2_q    <= 1'b0;
            end
        end
    end

    assign dbg2cif_e_debug_pd_cnt_rd_ack    = rd_ack_q;
    assign dbg2cif_c_debug_pd_cnt_rd_data   = rd_data_q;
    assign dbg2cif_c_debug_pd_capture_valid = cap_valid_q;

endmodule

// File: tb/tb_pd_debug_cnt.sv
// Directed bench for pd_debug_cnt (wrap build), narrow event counters and a 33-bit byte counter.
module tb_pd_debug_cnt;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        f1_inc = 0, f2_inc = 0, capm_inc = 0, tot_inc = 0;
    logic        f1b_inc = 0, f2b_inc = 0;
    logic [31:0] amount = '0;
    logic        strobe1 = 0, strobe2 = 0;
    logic [31:0] pd_out = '0;
    logic        clr_on_rd = 0, clr_all = 0, rd_req = 0;
    logic [3:0]  rd_addr = '0;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        cap_valid;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pd_debug_cnt #(.CNT_WIDTH(8), .BYTE_CNT_WIDTH(33), .PACKET_SIZE_WIDTH(32)) dut (
        .clk                                          (clk),
        .rstn                                         (rstn),
        .dbg2cif_e_debug_pd_field1_cnt_inc            (f1_inc),
        .dbg2cif_e_debug_pd_field2_cnt_inc            (f2_inc),
        .dbg2cif_e_debug_pd_capture_match_cnt_inc     (capm_inc),
        .dbg2cif_e_debug_pd_total_pd_cnt_inc          (tot_inc),
        .dbg2cif_e_debug_pd_field1_byte_cnt_inc       (f1b_inc),
        .dbg2cif_e_debug_pd_field2_byte_cnt_inc       (f2b_inc),
        .dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount(amount),
        .dbg2cif_e_debug_pd_capture_match_field1      (strobe1),
        .dbg2cif_e_debug_pd_capture_match_field2      (strobe2),
        .dbg2cif_c_debug_pd_out                       (pd_out),
        .cif2dbg_c_debug_pd_cnt_clr_on_rd             (clr_on_rd),
        .cif2dbg_e_debug_pd_cnt_clr_all               (clr_all),
        .cif2dbg_e_debug_pd_cnt_rd_req                (rd_req),
        .cif2dbg_c_debug_pd_cnt_rd_addr               (rd_addr),
        .dbg2cif_e_debug_pd_cnt_rd_ack                (rd_ack),
        .dbg2cif_c_debug_pd_cnt_rd_data               (rd_data),
        .dbg2cif_c_debug_pd_capture_valid             (cap_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a one-cycle read; side inputs set by the caller share that cycle.
    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
        chk({tag, "_ack"}, {31'b0, rd_ack}, 32'd1);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        #1;
        chk("rst_ack", {31'b0, rd_ack}, 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_capv", {31'b0, cap_valid}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        for (int a = 0; a < 10; a++) rd(4'(a), 32'd0, "reset_rd");
        tick();
        chk("ack_drop", {31'b0, rd_ack}, 32'd0);

        clr_on_rd = 1'b1;
        f1_inc = 1'b1;
        repeat (5) tick();
        f1_inc = 1'b0;
        rd(4'd0, 32'd5, "f1_cnt5");
        rd(4'd0, 32'd0, "f1_cleared");

        clr_on_rd = 1'b0;
        f1b_inc = 1'b1;
        amount = 32'hFFFF_FFF0;
        tick();
        amount = 32'h20;
        tick();
        f1b_inc = 1'b0;
        rd(4'd4, 32'h10, "f1b_lo");
        rd(4'd5, 32'h1, "f1b_hi");
        rd(4'd9, 32'h0, "status_noovf");
        f1b_inc = 1'b1;
        amount = 32'hFFFF_FFFF;
        tick();
        f1b_inc = 1'b0;
        rd(4'd4, 32'hF, "f1b_wrap_lo");
        rd(4'd5, 32'h0, "f1b_wrap_hi");
        rd(4'd9, 32'h200, "status_ovf_f1b");
        f2b_inc = 1'b1;
        amount = 32'h0;
        tick();
        f2b_inc = 1'b0;
        rd(4'd6, 32'h0, "f2b_amount0");

        clr_on_rd = 1'b1;
        tot_inc = 1'b1;
        repeat (2) tick();
        rd(4'd3, 32'd2, "tot_rdclr_old");
        tot_inc = 1'b0;
        rd(4'd3, 32'd1, "tot_after_inc");

        clr_on_rd = 1'b0;
        strobe2 = 1'b1;
        pd_out = 32'hA5A5_0001;
        tick();
        strobe2 = 1'b0;
        chk("capv_set", {31'b0, cap_valid}, 32'd1);
        strobe1 = 1'b1;
        pd_out = 32'h0000_1234;
        tick();
        strobe1 = 1'b0;
        rd(4'd8, 32'hA5A5_0001, "cap_word");
        rd(4'd9, 32'h20A, "status_cap_f2");
        clr_on_rd = 1'b1;
        strobe1 = 1'b1;
        pd_out = 32'h0000_BEEF;
        rd(4'd8, 32'hA5A5_0001, "cap_rdclr_old");
        strobe1 = 1'b0;
        rd(4'd9, 32'h209, "status_recap_f1");
        rd(4'd9, 32'h009, "status_ovf_clr");
        clr_on_rd = 1'b0;
        rd(4'd8, 32'h0000_BEEF, "cap_new_word");

        f2_inc = 1'b1;
        repeat (256) tick();
        f2_inc = 1'b0;
        rd(4'd1, 32'd0, "f2_wrap");
        rd(4'd9, 32'h029, "status_ovf_f2");

        f1_inc = 1'b1;
        tot_inc = 1'b1;
        repeat (7) tick();
        f1_inc = 1'b0;
        tot_inc = 1'b0;
        clr_all = 1'b1;
        rd(4'd0, 32'd7, "clrall_rd_old");
        clr_all = 1'b0;
        rd(4'd0, 32'd0, "clrall_f1");
        rd(4'd3, 32'd0, "clrall_tot");
        rd(4'd4, 32'd0, "clrall_f1b");
        rd(4'd8, 32'd0, "clrall_cap");
        rd(4'd9, 32'd0, "clrall_status");
        chk("clrall_capv", {31'b0, cap_valid}, 32'd0);

        f1_inc = 1'b1;
        repeat (3) tick();
        f1_inc = 1'b0;
        rd_req = 1'b1;
        rd_addr = 4'd2;
        tick();
        chk("b2b_ack0", {31'b0, rd_ack}, 32'd1);
        chk("b2b_data0", rd_data, 32'd0);
        rd_addr = 4'd0;
        tick();
        rd_req = 1'b0;
        chk("b2b_ack1", {31'b0, rd_ack}, 32'd1);
        chk("b2b_data1", rd_data, 32'd3);
        tick();
        chk("b2b_ack_drop", {31'b0, rd_ack}, 32'd0);
        chk("b2b_data_hold", rd_data, 32'd3);
        rd(4'd12, 32'd0, "unmapped");

        rd_req = 1'b1;
        rd_addr = 4'd0;
        tick();
        rd_req = 1'b0;
        chk("midrd_ack", {31'b0, rd_ack}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("midrd_rst_ack", {31'b0, rd_ack}, 32'd0);
        chk("midrd_rst_data", rd_data, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
